// File: rtl/icb_dma_master.sv
// Single-channel ICB copy engine: reads one 32-bit word from the source range,
// writes it to the destination range, and repeats with one transaction outstanding.
module icb_dma_master #(
    parameter int          LEN_W     = 13,
    parameter logic [31:0] ADDR_STEP = 32'd4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] words_done,
    output logic             icb_cmd_valid,
    input  logic             icb_cmd_ready,
    output logic             icb_cmd_read,
    output logic [31:0]      icb_cmd_addr,
    output logic [31:0]      icb_cmd_wdata,
    output logic [3:0]       icb_cmd_wmask,
    input  logic             icb_rsp_valid,
    output logic             icb_rsp_ready,
    input  logic [31:0]      icb_rsp_rdata,
    input  logic             icb_rsp_err
);

    typedef enum logic [2:0] {
        IDLE, RD_CMD, RD_RSP, WR_CMD, WR_RSP, FIN
    } state_e;

    state_e           state_q;
    logic [31:0]      src_q, dst_q, buf_q;
    logic [LEN_W-1:0] len_q, words_done_q;
    logic             cmd_valid_q, cmd_read_q, rsp_ready_q;
    logic [31:0]      cmd_addr_q;
    logic [3:0]       cmd_wmask_q;
    logic             busy_q, done_q, err_q;

    logic [31:0]      src_d, dst_d;
    logic [LEN_W-1:0] words_done_d;

    assign src_d        = src_q + ADDR_STEP;
    assign dst_d        = dst_q + ADDR_STEP;
    assign words_done_d = words_done_q + 1'b1;

    // NOTE: every flop below is assigned with <= so all state updates see the
    // pre-edge values; mixing in = here would create simulation/synthesis races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            buf_q        <= '0;
            len_q        <= '0;
            words_done_q <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_read_q   <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wmask_q  <= '0;
            rsp_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        err_q        <= 1'b0;
                        words_done_q <= '0;
                        if (len != '0) begin
                            src_q       <= src_addr;
                            dst_q       <= dst_addr;
                            len_q       <= len;
                            cmd_valid_q <= 1'b1;
                            cmd_read_q  <= 1'b1;
                            cmd_addr_q  <= src_addr;
                            cmd_wmask_q <= 4'h0;
                            busy_q      <= 1'b1;
                            state_q     <= RD_CMD;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end
                    end
                end
                RD_CMD, WR_CMD: begin
                    // Command fields stay frozen until the slave accepts.
                    if (icb_cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        rsp_ready_q <= 1'b1;
                        state_q     <= (state_q == RD_CMD) ? RD_RSP : WR_RSP;
                    end
                end
                RD_RSP: begin
                    if (icb_rsp_valid) begin
                        rsp_ready_q <= 1'b0;
                        if (icb_rsp_err) begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            buf_q       <= icb_rsp_rdata;
                            cmd_valid_q <= 1'b1;
                            cmd_read_q  <= 1'b0;
                            cmd_addr_q  <= dst_q;
                            cmd_wmask_q <= 4'hF;
                            state_q     <= WR_CMD;
                        end
                    end
                end
                WR_RSP: begin
                    if (icb_rsp_valid) begin
                        rsp_ready_q <= 1'b0;
                        if (icb_rsp_err) begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            words_done_q <= words_done_d;
                            src_q        <= src_d;
                            dst_q        <= dst_d;
                            if (words_done_d == len_q) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= FIN;
                            end else begin
                                cmd_valid_q <= 1'b1;
                                cmd_read_q  <= 1'b1;
                                cmd_addr_q  <= src_d;
                                cmd_wmask_q <= 4'h0;
                                state_q     <= RD_CMD;
                            end
                        end
                    end
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign words_done    = words_done_q;
    assign icb_cmd_valid = cmd_valid_q;
    assign icb_cmd_read  = cmd_read_q;
    assign icb_cmd_addr  = cmd_addr_q;
    assign icb_cmd_wdata = buf_q;
    assign icb_cmd_wmask = cmd_wmask_q;
    assign icb_rsp_ready = rsp_ready_q;

endmodule
